// File: rtl/y_alu_pkg.sv
// y_alu_pkg: shared constants for the ALU datapath blocks.
// Holds the multiplier state encoding and the default datapath word width.
package y_alu_pkg;

    localparam int Y_WORD_W = 32;

    localparam logic [1:0] Y_MULT_IDLE = 2'd0;
    localparam logic [1:0] Y_MULT_RUN  = 2'd1;
    localparam logic [1:0] Y_MULT_DONE = 2'd2;
    localparam logic [1:0] Y_MULT_FIX  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = Y_MULT_IDLE,
        ST_RUN  = Y_MULT_RUN,
        ST_DONE = Y_MULT_DONE,
        ST_FIX  = Y_MULT_FIX
    } y_mult_state_t;

endpackage

// File: rtl/y_mult_seq_adder.sv
// yAdder: 32-bit ripple-carry adder, {cout, z} = a + b + cin.
module yAdder
    import y_alu_pkg::*;
(
    output logic [Y_WORD_W-1:0] z,
    output logic                cout,
    input  logic [Y_WORD_W-1:0] a,
    input  logic [Y_WORD_W-1:0] b,
    input  logic                cin
);

    logic [Y_WORD_W:0] c;

    assign c[0] = cin;

    // one full adder per bit, carry rippling upward
    for (genvar i = 0; i < Y_WORD_W; i++) begin : g_fa
        assign z[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[Y_WORD_W];

endmodule

// File: rtl/y_mult_seq.sv
// y_mult_seq: iterative shift-add multiplier, one partial product per cycle.
// Product register P = {P_hi, P_lo}; P_lo starts as the multiplier and is
// shifted out as P_hi accumulates. Optional macro Y_MULT_SIGNED_EN switches
// to two's complement operands (magnitude multiply plus a final FIX negate).
module y_mult_seq
    import y_alu_pkg::*;
#(
    parameter int WIDTH = Y_WORD_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    y_mult_state_t          state, nxt;
    logic [WIDTH-1:0]       m;
    logic [2*WIDTH-1:0]     p;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       p_hi;
    logic [WIDTH-1:0]       sum;
    logic                   cout;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   accept;
    logic                   last;

    assign p_hi   = p[2*WIDTH-1:WIDTH];
    assign accept = in_valid && (state == ST_IDLE);
    assign last   = (cnt == CNT_W'(WIDTH-1));

`ifdef Y_MULT_SIGNED_EN
    // most-negative value maps onto itself, which is 2^(WIDTH-1) unsigned
    logic neg;
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // the adder carry-out lands in P_hi's MSB after the shift
    if (WIDTH == Y_WORD_W) begin : g_ripple
        yAdder u_add (
            .z    (sum),
            .cout (cout),
            .a    (p_hi),
            .b    (m),
            .cin  (1'b0)
        );
    end else begin : g_behav
        assign {cout, sum} = {1'b0, p_hi} + {1'b0, m};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    // next-state: accept in IDLE, WIDTH iterations, then hold until taken
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (in_valid) nxt = ST_RUN;
`ifdef Y_MULT_SIGNED_EN
            ST_RUN:  if (last) nxt = ST_FIX;
            ST_FIX:  nxt = ST_DONE;
`else
            ST_RUN:  if (last) nxt = ST_DONE;
`endif
            ST_DONE: if (out_ready) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // operand load, shift-add iteration, optional sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            p   <= '0;
            cnt <= '0;
`ifdef Y_MULT_SIGNED_EN
            neg <= 1'b0;
`endif
        end else if (accept) begin
            m   <= a_mag;
            p   <= {{WIDTH{1'b0}}, b_mag};
            cnt <= '0;
`ifdef Y_MULT_SIGNED_EN
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else if (state == ST_RUN) begin
            if (p[0]) p <= {cout, sum, p[WIDTH-1:1]};
            else      p <= {1'b0, p_hi, p[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
        end
`ifdef Y_MULT_SIGNED_EN
        else if (state == ST_FIX) begin
            if (neg) p <= -p;
        end
`endif
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign product   = p;

endmodule

// File: tb/tb_y_mult_seq.sv
// tb_y_mult_seq: directed bench for y_mult_seq with a product scoreboard.
// Expected products are queued at accept and checked when out_valid rises.
// Honours Y_MULT_SIGNED_EN for latency and signed-only vectors.
module tb_y_mult_seq;

`ifdef Y_MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    logic [63:0] sb[$];
    int          passed = 0;
    int          total  = 0;

    y_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // present operands in IDLE; queue the expected product on the accepting edge
    task automatic accept(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // count cycles to out_valid; optionally poke in_valid mid-run to show it is ignored
    task automatic wait_out(input string tag, input bit poke);
        int cyc = 0;
        logic [63:0] exp;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 5) begin
                chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
                a = 32'd1;
                b = 32'd1;
                in_valid = 1'b1;
            end
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_product"}, product, exp);
    endtask

    // hold off out_ready for stall cycles, then take the product
    task automatic finish(input string tag, input int stall);
        logic [63:0] held;
        held = product;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_stall_product"}, product, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_post_hold"}, product, held);
    endtask

    initial begin
        bit saw_valid;
        logic [31:0] ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic small product
        accept("m3x5", 32'd3, 32'd5, 64'd15);
        wait_out("m3x5", 1'b0);
        finish("m3x5", 0);

`ifndef Y_MULT_SIGNED_EN
        // carry-out into P_hi every iteration
        accept("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_out("mff", 1'b0);
        finish("mff", 0);

        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom;
            accept("mrand", ra, rb, {32'd0, ra} * {32'd0, rb});
            wait_out("mrand", 1'b0);
            finish("mrand", 0);
        end
`endif

        // zero on either side
        accept("m0xb", 32'd0, 32'h1234_5678, 64'd0);
        wait_out("m0xb", 1'b0);
        finish("m0xb", 0);
        accept("max0", 32'h1234_5678, 32'd0, 64'd0);
        wait_out("max0", 1'b0);
        finish("max0", 0);

        // backpressure plus ignored in_valid during RUN/DONE
        accept("m7x9", 32'd7, 32'd9, 64'd63);
        wait_out("m7x9", 1'b1);
        finish("m7x9", 10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("m7x9_no_ghost", 64'(out_valid), 64'd0);
        end

        // reset mid-run discards the operation
        accept("mrst", 32'd100, 32'd200, 64'd20000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_product", product, 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mrst_no_pulse", 64'(saw_valid), 64'd0);
        accept("m2x3", 32'd2, 32'd3, 64'd6);
        wait_out("m2x3", 1'b0);
        finish("m2x3", 0);

`ifdef Y_MULT_SIGNED_EN
        accept("sneg3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_out("sneg3x5", 1'b0);
        finish("sneg3x5", 0);
        accept("smin", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_out("smin", 1'b0);
        finish("smin", 0);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/y_mult_seq.md
Name: y_mult_seq

Overview:
- Iterative shift-add unsigned multiplier: WIDTH x WIDTH operands, 2*WIDTH product.
- Sits directly upstream of the 32-bit ripple adder. Each cycle it feeds the adder one partial-sum operand pair and consumes its sum and carry-out.
- First multi-cycle datapath block in the ALU path.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width in bits. Product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer takes the product.
- product  out  2*WIDTH  result, {P_hi, P_lo}.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, multiplicand register M=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid & in_ready. Same edge loads M<=a, P_hi<=0, P_lo<=b, counter<=0.
- RUN, each edge:
  - If P_lo[0]=1: {cout, sum} = P_hi + M with cin=0; {P_hi,P_lo} <= {cout, sum, P_lo[WIDTH-1:1]}.
  - Else: {P_hi,P_lo} <= {1'b0, P_hi, P_lo[WIDTH-1:1]}.
  - counter <= counter+1.
- RUN -> DONE on the edge where counter==WIDTH-1 (WIDTH iterations total).
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge (32 for the default).
- DONE -> IDLE on out_valid & out_ready. product holds its value after the handshake until the next accept.
- Backpressure: in DONE, product and out_valid stay stable while out_ready=0, for any duration.
- in_valid while in RUN or DONE is ignored. The operands are not captured; the upstream must hold them until in_ready.
- No back-to-back overlap: the next accept occurs in IDLE, at the earliest one cycle after the output handshake.
- Width rule: the adder carry-out becomes P_hi[WIDTH-1] after the shift. There is no overflow: the product is exact modulo 2^(2*WIDTH).
- rst_n asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- out_ready while not in DONE: no effect.

Optional Feature:
- Macro: Y_MULT_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - The accepting edge loads M<=|a| and P_lo<=|b|, and latches neg = a[WIDTH-1]^b[WIDTH-1].
  - Extra state FIX after RUN: product <= neg ? -product : product. FIX -> DONE.
  - Latency is WIDTH+1 cycles.
  - The most-negative operand's magnitude is treated as unsigned 2^(WIDTH-1), which gives the correct result.
- Undefined: unsigned operation, no FIX state, latency WIDTH, no neg register.

Decomposition:
- Shared package y_alu_pkg:
  - state encoding constants Y_MULT_IDLE=2'd0, Y_MULT_RUN=2'd1, Y_MULT_DONE=2'd2, Y_MULT_FIX=2'd3;
  - default width constant Y_WORD_W=32.
- Sub-module: one instance of yAdder, port order (z, cout, a, b, cin) with cin tied 0, for WIDTH=32.
- For WIDTH other than 32, a behavioural WIDTH+1-bit add replaces the instance under a generate branch.
- Control FSM and shift registers are in y_mult_seq itself.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid exactly 32 cycles after accept; product=64'd15; in_ready returns 1 the cycle after the handshake.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; carry path exercised every iteration.
- a=0, b=32'h12345678, then a=32'h12345678, b=0 -> product=0 both times, latency still 32.
- a=7, b=9, out_ready held 0 for 10 cycles after out_valid -> product=63 stable and out_valid high throughout; a new in_valid pulse with a=1, b=1 during RUN/DONE is ignored.
- Accept a=100, b=200; drop rst_n at cycle 10 for 1 cycle -> out_valid=0, product=0, in_ready=1; a new op a=2, b=3 then gives 6 after 32 cycles.
- Y_MULT_SIGNED_EN: a=-3, b=5 -> product=64'hFFFFFFFFFFFFFFF1 at 33 cycles; a=32'h80000000, b=-1 -> product=64'h0000000080000000.
